// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the two requester ports and the shared memory port of the
// two-to-one memory arbiter.
//   m0_* / m1_* : requester address, write data, byte strobe, read strobe,
//                 returned read data and read/write busy flags.
//   s_*         : shared memory address, write data, byte strobe, read
//                 strobe and read data (valid one cycle after s_rstrb).
// Modports:
//   slave  : the arbiter side (takes requests, drives the shared port).
//   master : the environment side (issues requests, models the memory).
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wmask;
  logic        m0_rstrb;
  logic [31:0] m0_rdata;
  logic        m0_rbusy;
  logic        m0_wbusy;

  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wmask;
  logic        m1_rstrb;
  logic [31:0] m1_rdata;
  logic        m1_rbusy;
  logic        m1_wbusy;

  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wmask;
  logic        s_rstrb;
  logic [31:0] s_rdata;

  modport slave (
    input  m0_addr, m0_wdata, m0_wmask, m0_rstrb,
    output m0_rdata, m0_rbusy, m0_wbusy,
    input  m1_addr, m1_wdata, m1_wmask, m1_rstrb,
    output m1_rdata, m1_rbusy, m1_wbusy,
    output s_addr, s_wdata, s_wmask, s_rstrb,
    input  s_rdata
  );

  modport master (
    output m0_addr, m0_wdata, m0_wmask, m0_rstrb,
    input  m0_rdata, m0_rbusy, m0_wbusy,
    output m1_addr, m1_wdata, m1_wmask, m1_rstrb,
    input  m1_rdata, m1_rbusy, m1_wbusy,
    input  s_addr, s_wdata, s_wmask, s_rstrb,
    output s_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Two requesters share a single-ported memory. Each requester owns one
// pending slot; the arbiter issues one slot per idle cycle on the shared
// port and, for reads, waits one cycle for the memory data, which it
// registers into that requester's read-data output.
// Ports:
//   clk  : clock, all state changes on the rising edge.
//   rstn : asynchronous active-low reset.
//   bus  : mem_arbiter_if.slave (requester ports and shared memory port).
// Parameter:
//   FIXED_PRIO : 0 = round-robin on ties, 1 = requester 0 always wins ties.
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rstn,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_DATA = 1'b1
  } state_t;

  // Requester inputs gathered into index-able vectors (index 0 = m0).
  logic [1:0][31:0] w_in_addr;
  logic [1:0][31:0] w_in_wdata;
  logic [1:0][3:0]  w_in_wmask;
  logic [1:0]       w_in_rstrb;
  logic [1:0]       w_in_wr;
  logic [1:0]       w_in_req;

  // Pending slots.
  logic [1:0][31:0] r_slot_addr;
  logic [1:0][31:0] r_slot_wdata;
  logic [1:0][3:0]  r_slot_wmask;
  logic [1:0]       r_slot_rd;
  logic [1:0]       r_slot_vld;

  state_t           r_state;
  logic             r_last_gnt;   // 1 = m1 was granted last
  logic             r_rd_owner;   // requester whose read is in flight
  logic [1:0][31:0] r_rdata;

  logic             w_issue;
  logic             w_gnt;
  logic [1:0]       w_inflight;
  logic [1:0]       w_cap;
  logic [1:0]       w_rbusy;
  logic [1:0]       w_wbusy;

  // Gather interface inputs into vectors.
  always_comb begin
    w_in_addr[0]  = bus.m0_addr;
    w_in_addr[1]  = bus.m1_addr;
    w_in_wdata[0] = bus.m0_wdata;
    w_in_wdata[1] = bus.m1_wdata;
    w_in_wmask[0] = bus.m0_wmask;
    w_in_wmask[1] = bus.m1_wmask;
    w_in_rstrb[0] = bus.m0_rstrb;
    w_in_rstrb[1] = bus.m1_rstrb;
    for (int i = 0; i < 2; i++) begin
      w_in_wr[i]  = |w_in_wmask[i];
      w_in_req[i] = w_in_wr[i] | w_in_rstrb[i];
    end
  end

  // Grant selection: single requester wins outright; ties go by policy.
  always_comb begin
    w_issue = (r_state == IDLE) && (|r_slot_vld);
    if (r_slot_vld == 2'b11) begin
      if (FIXED_PRIO) begin
        w_gnt = 1'b0;
      end else begin
        w_gnt = ~r_last_gnt;
      end
    end else if (r_slot_vld[0]) begin
      w_gnt = 1'b0;
    end else begin
      w_gnt = 1'b1;
    end
  end

  // Busy flags and capture enables. A requester is blocked while its slot
  // holds a request or while its read is waiting for memory data, so each
  // requester has at most one access in the system.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_inflight[i] = (r_state == WAIT_DATA) && (r_rd_owner == i[0]);
      w_cap[i]      = w_in_req[i] && !r_slot_vld[i] && !w_inflight[i];
      w_rbusy[i]    = rstn & (w_in_rstrb[i] | (r_slot_vld[i] & r_slot_rd[i]) | w_inflight[i]);
      w_wbusy[i]    = rstn & (w_in_wr[i] | (r_slot_vld[i] & ~r_slot_rd[i]));
    end
  end

  // Shared-port drive: the winning slot is presented in the issue cycle,
  // everything is held at zero otherwise.
  always_comb begin
    if (w_issue) begin
      bus.s_addr = r_slot_addr[w_gnt];
      if (r_slot_rd[w_gnt]) begin
        bus.s_rstrb = 1'b1;
        bus.s_wmask = 4'h0;
        bus.s_wdata = 32'h0;
      end else begin
        bus.s_rstrb = 1'b0;
        bus.s_wmask = r_slot_wmask[w_gnt];
        bus.s_wdata = r_slot_wdata[w_gnt];
      end
    end else begin
      bus.s_addr  = 32'h0;
      bus.s_rstrb = 1'b0;
      bus.s_wmask = 4'h0;
      bus.s_wdata = 32'h0;
    end
  end

  // Requester-facing outputs.
  always_comb begin
    bus.m0_rdata = r_rdata[0];
    bus.m1_rdata = r_rdata[1];
    bus.m0_rbusy = w_rbusy[0];
    bus.m1_rbusy = w_rbusy[1];
    bus.m0_wbusy = w_wbusy[0];
    bus.m1_wbusy = w_wbusy[1];
  end

  // Slot capture/clear, arbitration state and read-data return.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_slot_addr  <= '0;
      r_slot_wdata <= '0;
      r_slot_wmask <= '0;
      r_slot_rd    <= 2'b00;
      r_slot_vld   <= 2'b00;
      r_state      <= IDLE;
      r_last_gnt   <= 1'b1;
      r_rd_owner   <= 1'b0;
      r_rdata      <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_issue && (w_gnt == i[0])) begin
          r_slot_vld[i] <= 1'b0;
        end else if (w_cap[i]) begin
          // A write strobe takes precedence over a same-cycle read strobe.
          r_slot_vld[i]   <= 1'b1;
          r_slot_addr[i]  <= w_in_addr[i];
          r_slot_wdata[i] <= w_in_wdata[i];
          r_slot_wmask[i] <= w_in_wmask[i];
          r_slot_rd[i]    <= ~w_in_wr[i];
        end else begin
          r_slot_vld[i] <= r_slot_vld[i];
        end
      end

      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_last_gnt <= w_gnt;
            if (r_slot_rd[w_gnt]) begin
              r_rd_owner <= w_gnt;
              r_state    <= WAIT_DATA;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT_DATA: begin
          r_rdata[r_rd_owner] <= bus.s_rdata;
          r_state             <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Bench for mem_arbiter. Instance A (round-robin) sits on a byte-maskable
// memory model; instance B (fixed priority) returns ~addr as read data.
// Requester 1 reads use addresses >= 0x1000 so the read monitor can tell
// the owner of each shared-port read from the address alone.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mem_arbiter_if bus_a ();
  mem_arbiter_if bus_b ();

  mem_arbiter #(.FIXED_PRIO(1'b0)) u_dut_a (.clk(clk), .rstn(rstn), .bus(bus_a.slave));
  mem_arbiter #(.FIXED_PRIO(1'b1)) u_dut_b (.clk(clk), .rstn(rstn), .bus(bus_b.slave));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rd_cnt1  = 0;

  typedef struct { bit own; int due; } pend_t;
  pend_t       pend_q[$];
  pend_t       mon_p;
  bit          mon_own;
  bit          gnt_log[$];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] mem [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model for instance A: one-cycle read latency, byte-masked writes.
  always @(posedge clk) begin
    logic [31:0] v;
    bus_a.s_rdata <= bus_a.s_rstrb ? mem_rd(bus_a.s_addr) : 32'h0;
    if (bus_a.s_wmask != 4'h0) begin
      v = mem_rd(bus_a.s_addr);
      for (int b = 0; b < 4; b++)
        if (bus_a.s_wmask[b]) v[8*b +: 8] = bus_a.s_wdata[8*b +: 8];
      mem[bus_a.s_addr] = v;
    end
  end

  // Memory model for instance B.
  always @(posedge clk) bus_b.s_rdata <= bus_b.s_rstrb ? ~bus_b.s_addr : 32'h0;

  // Read scoreboard for instance A: each shared read must show the expected
  // data on its owner's rdata two cycles after the strobe.
  always @(negedge clk) begin
    if (!rstn) begin
      pend_q.delete();
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        mon_p = pend_q.pop_front();
        if (mon_p.own == 1'b0) begin
          if (exp_q0.size() == 0) check("sb_m0_unexpected_read", 32'd1, 32'd0);
          else check("sb_m0_rdata", bus_a.m0_rdata, exp_q0.pop_front());
        end else begin
          if (exp_q1.size() == 0) check("sb_m1_unexpected_read", 32'd1, 32'd0);
          else check("sb_m1_rdata", bus_a.m1_rdata, exp_q1.pop_front());
        end
      end
      if (bus_a.s_rstrb) begin
        mon_own = (bus_a.s_addr >= 32'h1000);
        pend_q.push_back('{mon_own, cyc + 2});
        gnt_log.push_back(mon_own);
        if (mon_own) rd_cnt1++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus_a.m0_rstrb = 1'b0; bus_a.m0_wmask = 4'h0;
    bus_a.m1_rstrb = 1'b0; bus_a.m1_wmask = 4'h0;
    bus_b.m0_rstrb = 1'b0; bus_b.m0_wmask = 4'h0;
    bus_b.m1_rstrb = 1'b0; bus_b.m1_wmask = 4'h0;
  endtask

  task automatic pulse_reset();
    step();
    rstn = 1'b0;
    clear_in();
    step();
    rstn = 1'b1;
  endtask

  // Repeatedly read on instance A, re-strobing in the first cycle busy drops.
  task automatic reread(input bit who, input int n);
    int budget;
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      a = (who ? 32'h1200 : 32'h200) + 32'(4 * k);
      if (who) begin
        bus_a.m1_addr = a; bus_a.m1_rstrb = 1'b1; exp_q1.push_back(mem_rd(a));
      end else begin
        bus_a.m0_addr = a; bus_a.m0_rstrb = 1'b1; exp_q0.push_back(mem_rd(a));
      end
      @(posedge clk); #1;
      if (who) bus_a.m1_rstrb = 1'b0; else bus_a.m0_rstrb = 1'b0;
      #1;
      budget = 0;
      while ((who ? bus_a.m1_rbusy : bus_a.m0_rbusy) && budget < 20) begin
        @(posedge clk); #2;
        budget++;
      end
      if (budget >= 20) check("t5_busy_timeout", 32'(budget), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    rstn = 1'b0;
    clear_in();
    bus_a.m0_addr = 32'h0; bus_a.m0_wdata = 32'h0;
    bus_a.m1_addr = 32'h0; bus_a.m1_wdata = 32'h0;
    bus_b.m0_addr = 32'h0; bus_b.m0_wdata = 32'h0;
    bus_b.m1_addr = 32'h0; bus_b.m1_wdata = 32'h0;
    mem[32'h100]  = 32'hDEADBEEF;
    mem[32'h10]   = 32'hCAFEF00D;
    mem[32'h20]   = 32'h0;
    mem[32'h30]   = 32'h11223344;
    mem[32'h140]  = 32'h55550140;
    mem[32'h1080] = 32'h0BAD1080;
    mem[32'h1140] = 32'hAAAA1140;
    for (int i = 0; i < 4; i++) begin
      mem[32'h200 + 32'(4 * i)]  = 32'h20000000 + 32'(i);
      mem[32'h1200 + 32'(4 * i)] = 32'h30000000 + 32'(i);
    end
    step(); step();

    // Reset: outputs held low even with strobes present.
    bus_a.m0_rstrb = 1'b1; bus_a.m1_wmask = 4'hF;
    @(negedge clk);
    check("rst_m0_rbusy", 32'(bus_a.m0_rbusy), 32'd0);
    check("rst_m1_wbusy", 32'(bus_a.m1_wbusy), 32'd0);
    check("rst_s_rstrb",  32'(bus_a.s_rstrb),  32'd0);
    check("rst_s_wmask",  32'(bus_a.s_wmask),  32'd0);
    check("rst_s_addr",   bus_a.s_addr,        32'h0);
    check("rst_m0_rdata", bus_a.m0_rdata,      32'h0);
    check("rst_m1_rdata", bus_a.m1_rdata,      32'h0);

    // Uncontended read issued in the cycle reset releases.
    step();
    rstn = 1'b1;
    bus_a.m1_wmask = 4'h0;
    bus_a.m0_rstrb = 1'b1; bus_a.m0_addr = 32'h100;
    exp_q0.push_back(mem_rd(32'h100));
    @(negedge clk);
    check("t1_T_rbusy",  32'(bus_a.m0_rbusy), 32'd1);
    check("t1_T_srstrb", 32'(bus_a.s_rstrb),  32'd0);
    step(); clear_in();
    @(negedge clk);
    check("t1_T1_srstrb", 32'(bus_a.s_rstrb), 32'd1);
    check("t1_T1_saddr",  bus_a.s_addr,       32'h100);
    step();
    @(negedge clk);
    check("t1_T2_rbusy",  32'(bus_a.m0_rbusy), 32'd1);
    check("t1_T2_saddr",  bus_a.s_addr,        32'h0);
    step();
    @(negedge clk);
    check("t1_T3_rbusy", 32'(bus_a.m0_rbusy), 32'd0);
    check("t1_T3_rdata", bus_a.m0_rdata,      32'hDEADBEEF);

    // Contended m0 read vs m1 write right after reset.
    pulse_reset();
    step();
    bus_a.m0_rstrb = 1'b1; bus_a.m0_addr = 32'h10;
    exp_q0.push_back(mem_rd(32'h10));
    bus_a.m1_wmask = 4'hF; bus_a.m1_addr = 32'h20; bus_a.m1_wdata = 32'h12345678;
    @(negedge clk);
    check("t2_T_wbusy", 32'(bus_a.m1_wbusy), 32'd1);
    step(); clear_in();
    @(negedge clk);
    check("t2_T1_srstrb", 32'(bus_a.s_rstrb), 32'd1);
    check("t2_T1_saddr",  bus_a.s_addr,       32'h10);
    check("t2_T1_swmask", 32'(bus_a.s_wmask), 32'd0);
    step();
    @(negedge clk);
    check("t2_T2_swmask", 32'(bus_a.s_wmask),  32'd0);
    check("t2_T2_wbusy",  32'(bus_a.m1_wbusy), 32'd1);
    step();
    @(negedge clk);
    check("t2_T3_swmask", 32'(bus_a.s_wmask),  32'hF);
    check("t2_T3_saddr",  bus_a.s_addr,        32'h20);
    check("t2_T3_swdata", bus_a.s_wdata,       32'h12345678);
    check("t2_T3_wbusy",  32'(bus_a.m1_wbusy), 32'd1);
    step();
    @(negedge clk);
    check("t2_T4_wbusy", 32'(bus_a.m1_wbusy), 32'd0);
    check("t2_mem20",    mem_rd(32'h20),      32'h12345678);

    // Strobes while busy are dropped.
    step();
    start = rd_cnt1;
    bus_a.m1_rstrb = 1'b1; bus_a.m1_addr = 32'h1080;
    exp_q1.push_back(mem_rd(32'h1080));
    step();
    bus_a.m1_addr = 32'h10C0;
    @(negedge clk);
    check("t3_T1_rbusy", 32'(bus_a.m1_rbusy), 32'd1);
    step();
    bus_a.m1_addr = 32'h10C4;
    step(); clear_in();
    step(); step(); step();
    check("t3_m1_reads", 32'(rd_cnt1 - start), 32'd1);
    check("t3_m1_rdata", bus_a.m1_rdata,       32'h0BAD1080);

    // Same-cycle byte write and read strobe: write only.
    step();
    bus_a.m0_wmask = 4'h4; bus_a.m0_rstrb = 1'b1;
    bus_a.m0_addr = 32'h30; bus_a.m0_wdata = 32'h00AB0000;
    @(negedge clk);
    check("t4_T_wbusy", 32'(bus_a.m0_wbusy), 32'd1);
    step(); clear_in();
    @(negedge clk);
    check("t4_T1_swmask", 32'(bus_a.s_wmask),  32'h4);
    check("t4_T1_srstrb", 32'(bus_a.s_rstrb),  32'd0);
    check("t4_T1_rbusy",  32'(bus_a.m0_rbusy), 32'd0);
    step();
    @(negedge clk);
    check("t4_T2_rbusy",  32'(bus_a.m0_rbusy), 32'd0);
    check("t4_T2_wbusy",  32'(bus_a.m0_wbusy), 32'd0);
    check("t4_mem30",     mem_rd(32'h30),      32'h11AB3344);
    check("t4_m0_hold",   bus_a.m0_rdata,      32'hCAFEF00D);

    // Continuous rereads from both requesters alternate.
    step();
    start = gnt_log.size();
    fork
      reread(1'b0, 4);
      reread(1'b1, 4);
    join
    step(); step(); step();
    check("t5_n_grants", 32'(gnt_log.size() - start), 32'd8);
    for (int i = start + 1; i < gnt_log.size(); i++)
      check("t5_alternate", 32'(gnt_log[i]), 32'(!gnt_log[i-1]));

    // Reset during WAIT_DATA discards the read; m1 then reads normally.
    step();
    bus_a.m0_rstrb = 1'b1; bus_a.m0_addr = 32'h140;
    exp_q0.push_back(mem_rd(32'h140));
    step(); clear_in();
    step();
    rstn = 1'b0;
    @(negedge clk);
    check("t6_m0_rbusy", 32'(bus_a.m0_rbusy), 32'd0);
    check("t6_m0_wbusy", 32'(bus_a.m0_wbusy), 32'd0);
    check("t6_m1_rbusy", 32'(bus_a.m1_rbusy), 32'd0);
    check("t6_m0_rdata", bus_a.m0_rdata,      32'h0);
    check("t6_srstrb",   32'(bus_a.s_rstrb),  32'd0);
    step();
    rstn = 1'b1;
    bus_a.m1_rstrb = 1'b1; bus_a.m1_addr = 32'h1140;
    exp_q1.push_back(mem_rd(32'h1140));
    step(); clear_in();
    step(); step();
    @(negedge clk);
    check("t6_m1_rbusy", 32'(bus_a.m1_rbusy), 32'd0);
    check("t6_m1_rdata", bus_a.m1_rdata,      32'hAAAA1140);
    check("t6_m0_rdata_post", bus_a.m0_rdata, 32'h0);

    // Fixed priority: m0 wins a tie even right after m0 was granted.
    step();
    bus_b.m0_rstrb = 1'b1; bus_b.m0_addr = 32'h40;
    step(); clear_in();
    step(); step();
    step();
    bus_b.m0_rstrb = 1'b1; bus_b.m0_addr = 32'h44;
    bus_b.m1_rstrb = 1'b1; bus_b.m1_addr = 32'h1044;
    step(); clear_in();
    @(negedge clk);
    check("t7_T1_srstrb", 32'(bus_b.s_rstrb), 32'd1);
    check("t7_T1_saddr",  bus_b.s_addr,       32'h44);
    step(); step();
    @(negedge clk);
    check("t7_T3_srstrb", 32'(bus_b.s_rstrb), 32'd1);
    check("t7_T3_saddr",  bus_b.s_addr,       32'h1044);
    step();
    @(negedge clk);
    check("t7_m0_rdata", bus_b.m0_rdata, ~32'h44);
    step();
    @(negedge clk);
    check("t7_m1_rdata", bus_b.m1_rdata, ~32'h1044);

    step();
    check("sb_m0_drained", 32'(exp_q0.size()), 32'd0);
    check("sb_m1_drained", 32'(exp_q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0; 0 = round-robin arbitration, 1 = m0 always wins.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 m0_addr / m1_addr  input  32  requester byte address.
REQ-005 m0_wdata / m1_wdata  input  32  requester write data, lanes pre-aligned.
REQ-006 m0_wmask / m1_wmask  input  4  byte write strobe; nonzero for one cycle = write request.
REQ-007 m0_rstrb / m1_rstrb  input  1  one-cycle read request pulse.
REQ-008 m0_rdata / m1_rdata  output  32  registered read data per requester.
REQ-009 m0_rbusy / m1_rbusy  output  1  read in progress for that requester.
REQ-010 m0_wbusy / m1_wbusy  output  1  write in progress for that requester.
REQ-011 s_addr, s_wdata  output  32  shared memory address and write data.
REQ-012 s_wmask  output  4  shared memory byte write strobe.
REQ-013 s_rstrb  output  1  shared memory read strobe.
REQ-014 s_rdata  input  32  shared memory read data, valid exactly one cycle after s_rstrb.

Function
REQ-015 Each requester SHALL own one pending slot (addr, wdata, wmask, is_read, valid), captured at the edge ending a strobe cycle.
REQ-016 Request capture SHALL occur only when that requester's slot is empty; strobes while its busy is high SHALL be dropped, slot unchanged.
REQ-017 Same-cycle rstrb and nonzero wmask from one requester SHALL be captured as a write; read dropped.
REQ-018 mX_rbusy SHALL be combinational: mX_rstrb OR (slot read pending) OR (read of X in flight); mX_wbusy likewise for writes.
REQ-019 FSM states: IDLE, WAIT_DATA.
REQ-020 IDLE with >=1 valid slot: winner's slot SHALL drive s_addr/s_wdata and s_rstrb (read) or s_wmask (write) combinationally in that cycle; winner slot cleared at edge.
REQ-021 IDLE -> WAIT_DATA after issuing a read; IDLE -> IDLE after a write or with no pending slot.
REQ-022 WAIT_DATA: no issue; s_rdata SHALL be registered into the granted requester's mX_rdata; -> IDLE.
REQ-023 Only one access outstanding on the shared port at any time.
REQ-024 When not issuing, s_rstrb = 0, s_wmask = 0, s_addr = 0, s_wdata = 0.
REQ-025 Round-robin: both valid -> grant requester not granted last; last_gnt updates only on issue.
REQ-026 FIXED_PRIO=1: both valid -> m0 granted.
REQ-027 Latency, uncontended: strobe cycle T, shared issue T+1; write busy low at T+2; read data valid and rbusy low at T+3.
REQ-028 Round-robin contended bound: a request SHALL issue no later than 2 cycles after its uncontended issue cycle.
REQ-029 A requester MAY strobe in the first cycle its busy is low; that strobe SHALL be captured.
REQ-030 mX_rdata SHALL hold its value until that requester's next completed read; the other requester's reads SHALL not alter it.

Reset
REQ-031 rstn low SHALL immediately clear both slots, state = IDLE, last_gnt = m1 (m0 wins first tie), m0_rdata = m1_rdata = 0.
REQ-032 During reset all busy outputs, s_rstrb, s_wmask, s_addr, s_wdata SHALL be 0; in-flight read data discarded.
REQ-033 Strobes in the cycle rstn deasserts SHALL be captured normally at the next rising edge.

Verification
REQ-034 m0_rstrb at T, addr 0x100, mem[0x100]=0xDEADBEEF -> s_rstrb at T+1 addr 0x100; m0_rdata=0xDEADBEEF, m0_rbusy=0 at T+3.
REQ-035 m0 read 0x10 and m1 write 0x20 wmask 0xF data 0x12345678 both at T, FIXED_PRIO=0 after reset -> m0 issues T+1, m1 write issues T+3; m1_wbusy low T+4; mem[0x20]=0x12345678.
REQ-036 Both requesters continuously reread; round-robin -> grants strictly alternate m0,m1,m0,...; FIXED_PRIO=1 -> m0 wins every tie.
REQ-037 m1 strobes again while m1_rbusy=1 -> second request dropped; exactly one s_rstrb for m1.
REQ-038 rstn low during WAIT_DATA for m0 read -> busy outputs 0, m0_rdata=0; post-reset m1 read completes in 3 cycles.
REQ-039 m0 byte write wmask 0x4 same cycle as rstrb -> only s_wmask=0x4 issued, no s_rstrb, m0_rbusy never asserts after T.
